// File: rtl/sound_scheduler_if.sv
// Event/sound bundle between the game controller (master) and the sound scheduler (slave).
interface sound_scheduler_if;
  logic       hit;
  logic       wall;
  logic       goal;
  logic       mute;
  logic       sound;
  logic       busy;
  logic [1:0] playing;

  modport master (
    output hit, wall, goal, mute,
    input  sound, busy, playing
  );

  modport slave (
    input  hit, wall, goal, mute,
    output sound, busy, playing
  );
endinterface

// File: rtl/sound_scheduler.sv
// Arbitrates hit/wall/goal events onto one square-wave sound output.
// Fixed priority goal > hit > wall; goal plays two notes and preempts hit/wall tones.
module sound_scheduler #(
  parameter int unsigned HIT_HALF   = 56818,
  parameter int unsigned WALL_HALF  = 113636,
  parameter int unsigned GOAL1_HALF = 37878,
  parameter int unsigned GOAL2_HALF = 28409,
  parameter int unsigned TONE_LEN   = 2500000,
  parameter int unsigned GAP_LEN    = 500000,
  parameter int unsigned CW         = 24
) (
  input logic              clk,
  input logic              rst_n,
  sound_scheduler_if.slave bus
);

  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcWall = 2'd1;
  localparam logic [1:0] SrcHit  = 2'd2;
  localparam logic [1:0] SrcGoal = 2'd3;

  localparam logic [CW-1:0] HitHalf   = CW'(HIT_HALF);
  localparam logic [CW-1:0] WallHalf  = CW'(WALL_HALF);
  localparam logic [CW-1:0] Goal1Half = CW'(GOAL1_HALF);
  localparam logic [CW-1:0] Goal2Half = CW'(GOAL2_HALF);
  localparam logic [CW-1:0] ToneLast  = CW'(TONE_LEN - 1);
  localparam logic [CW-1:0] GapLast   = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] One       = CW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StTone,
    StGap,
    StGoal2,
    StGap2
  } state_e;

  state_e        r_state;
  logic [1:0]    r_src;
  logic          r_busy;
  logic [CW-1:0] r_half;
  logic [CW-1:0] r_dur;
  logic [CW-1:0] r_half_cnt;
  logic          r_wave;
  logic          r_sound;
  // Event bit order everywhere: {goal, hit, wall}.
  logic [2:0]    r_prev;
  logic [2:0]    r_pend;

  logic [2:0]    w_evt;
  logic [2:0]    w_rise;
  logic [2:0]    w_grant;
  logic [1:0]    w_grant_src;
  logic [CW-1:0] w_grant_half;
  logic          w_in_tone;
  logic          w_half_hit;
  logic          w_tone_last;
  logic          w_gap_last;
  logic          w_preempt;
  logic          w_tone_hold;
  logic          w_wave_next;

  assign w_evt  = {bus.goal, bus.hit, bus.wall};
  assign w_rise = w_evt & ~r_prev;

  always_comb begin
    w_grant      = 3'b000;
    w_grant_src  = SrcNone;
    w_grant_half = '0;
    if (r_state == StIdle) begin
      if (r_pend[2]) begin
        w_grant      = 3'b100;
        w_grant_src  = SrcGoal;
        w_grant_half = Goal1Half;
      end else if (r_pend[1]) begin
        w_grant      = 3'b010;
        w_grant_src  = SrcHit;
        w_grant_half = HitHalf;
      end else if (r_pend[0]) begin
        w_grant      = 3'b001;
        w_grant_src  = SrcWall;
        w_grant_half = WallHalf;
      end
    end
  end

  assign w_in_tone   = (r_state == StTone) || (r_state == StGoal2);
  assign w_half_hit  = (r_half_cnt == (r_half - One));
  assign w_tone_last = (r_dur == ToneLast);
  assign w_gap_last  = (r_dur == GapLast);
  // A goal that slipped in on the grant edge is already pending, so it aborts one cycle later.
  assign w_preempt   = (r_state == StTone) && (r_src != SrcGoal) && (w_rise[2] || r_pend[2]);
  assign w_tone_hold = w_in_tone && !w_tone_last && !w_preempt;
  // Every entry into a tone starts the waveform low, so only a held tone can carry phase.
  assign w_wave_next = w_tone_hold && (r_wave ^ w_half_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_src      <= SrcNone;
      r_busy     <= 1'b0;
      r_half     <= '0;
      r_dur      <= '0;
      r_half_cnt <= '0;
      r_wave     <= 1'b0;
      r_sound    <= 1'b0;
      r_prev     <= '0;
      r_pend     <= '0;
    end else begin
      r_prev     <= w_evt;
      r_pend     <= (r_pend & ~w_grant) | w_rise;
      r_half_cnt <= (w_tone_hold && !w_half_hit) ? r_half_cnt + One : '0;
      r_wave     <= w_wave_next;
      // Mute only gates the pin; the phase in r_wave keeps running underneath.
      r_sound    <= w_wave_next & ~bus.mute;

      unique case (r_state)
        StIdle: begin
          if (|w_grant) begin
            r_state <= StTone;
            r_src   <= w_grant_src;
            r_half  <= w_grant_half;
            r_busy  <= 1'b1;
            r_dur   <= '0;
          end
        end
        StTone: begin
          if (w_preempt || w_tone_last) begin
            r_state <= (!w_preempt && (r_src == SrcGoal)) ? StGap2 : StGap;
            r_dur   <= '0;
          end else begin
            r_dur <= r_dur + One;
          end
        end
        StGap2: begin
          if (w_gap_last) begin
            r_state <= StGoal2;
            r_half  <= Goal2Half;
            r_dur   <= '0;
          end else begin
            r_dur <= r_dur + One;
          end
        end
        StGoal2: begin
          if (w_tone_last) begin
            r_state <= StGap;
            r_dur   <= '0;
          end else begin
            r_dur <= r_dur + One;
          end
        end
        StGap: begin
          if (w_gap_last) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_src   <= SrcNone;
            r_dur   <= '0;
          end else begin
            r_dur <= r_dur + One;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.sound   = r_sound;
  assign bus.busy    = r_busy;
  assign bus.playing = r_src;

endmodule
